// File: rtl/pattern_pkg.sv
// Shared types and byte constants for the "boab" detector scheduler.
package pattern_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    STREAM,
    DRAIN,
    CLEAR,
    DONE
  } sched_state_t;

  localparam logic [7:0] CH_B    = 8'd98;
  localparam logic [7:0] CH_O    = 8'd111;
  localparam logic [7:0] CH_A    = 8'd97;
  localparam logic [7:0] CH_IDLE = 8'h00;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, one-hot and encoded.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  // scan requesters starting at ptr, wrapping, and keep the first hit
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pattern_scan_sched.sv
// Frame-atomic round-robin scheduler feeding one shared "boab" detector.
// A granted source owns the detector for a whole frame; the detector is
// flushed before each frame, drained with idle bytes after it, and every
// match is acknowledged and reported with the owning source id.
module pattern_scan_sched
  import pattern_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2,
  parameter int ACK_CYC   = 2
) (
  input  logic                       clk,
  input  logic                       reset_sync,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*8-1:0]         src_data,
  input  logic [N_SRC-1:0]           src_last,
  output logic [N_SRC-1:0]           src_ready,
  output logic [7:0]                 det_data,
  output logic                       det_ack,
  output logic                       det_reset,
  input  logic                       det_found,
  output logic                       match_pulse,
  output logic [$clog2(N_SRC)-1:0]   match_src,
  output logic                       frame_done,
  output logic [$clog2(N_SRC)-1:0]   frame_src,
  output logic [CNT_W-1:0]           frame_matches,
  output logic                       err_gap,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_SRC);

  sched_state_t     state, ret_state;
  logic [IDX_W-1:0] ptr, grant, arb_idx;
  logic [N_SRC-1:0] grant_oh, arb_gnt;
  logic             arb_any;
  logic [CNT_W-1:0] count;
  logic [7:0]       drain_cnt, ack_cnt;
  logic [7:0]       hold_data;
  logic             hold_vld;
  logic             det_reset_q;
  logic             grant_valid, grant_last;
  logic [7:0]       grant_byte;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req (src_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign grant_valid = src_valid[grant];
  assign grant_last  = src_last[grant];
  assign grant_byte  = src_data[{grant, 3'b000} +: 8];
  assign src_ready   = (state == STREAM) ? (grant_oh & src_valid) : '0;
  assign det_reset   = det_reset_q | reset_sync;
  assign busy        = (state != IDLE);

  // frame scheduler: grant, flush, stream, drain, match clearing, summary
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state         <= IDLE;
      ret_state     <= STREAM;
      ptr           <= '0;
      grant         <= '0;
      grant_oh      <= '0;
      count         <= '0;
      drain_cnt     <= '0;
      ack_cnt       <= '0;
      hold_data     <= '0;
      hold_vld      <= 1'b0;
      det_data      <= '0;
      det_ack       <= 1'b0;
      det_reset_q   <= 1'b0;
      match_pulse   <= 1'b0;
      match_src     <= '0;
      frame_done    <= 1'b0;
      frame_src     <= '0;
      frame_matches <= '0;
      err_gap       <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      frame_done  <= 1'b0;
      err_gap     <= 1'b0;
      det_reset_q <= 1'b0;
      det_ack     <= 1'b0;
      det_data    <= CH_IDLE;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant       <= arb_idx;
            grant_oh    <= arb_gnt;
            det_reset_q <= 1'b1;
            state       <= FLUSH;
          end
        end
        FLUSH: state <= STREAM;
        STREAM: begin
          if (grant_valid) det_data <= grant_byte;
          if (det_found) begin
            // a byte accepted alongside the match is parked until the ack ends
            match_pulse <= 1'b1;
            match_src   <= grant;
            count       <= sat_inc(count);
            det_ack     <= 1'b1;
            det_data    <= CH_IDLE;
            ack_cnt     <= 8'(ACK_CYC - 1);
            hold_vld    <= grant_valid;
            hold_data   <= grant_byte;
            state       <= CLEAR;
            if (!grant_valid || grant_last) begin
              err_gap   <= !grant_valid;
              ret_state <= DRAIN;
              drain_cnt <= 8'(DRAIN_CYC - 1);
            end else begin
              ret_state <= STREAM;
            end
          end else if (!grant_valid || grant_last) begin
            err_gap   <= !grant_valid;
            drain_cnt <= 8'(DRAIN_CYC - 1);
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (det_found) begin
            match_pulse <= 1'b1;
            match_src   <= grant;
            count       <= sat_inc(count);
            det_ack     <= 1'b1;
            ack_cnt     <= 8'(ACK_CYC - 1);
            hold_vld    <= 1'b0;
            ret_state   <= DRAIN;
            state       <= CLEAR;
          end else if (drain_cnt == 8'd0) begin
            frame_done    <= 1'b1;
            frame_src     <= grant;
            frame_matches <= count;
            state         <= DONE;
          end else begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end
        CLEAR: begin
          if (ack_cnt == 8'd0) begin
            det_data <= hold_vld ? hold_data : CH_IDLE;
            hold_vld <= 1'b0;
            state    <= ret_state;
          end else begin
            det_ack <= 1'b1;
            ack_cnt <= ack_cnt - 8'd1;
          end
        end
        DONE: begin
          count <= '0;
          ptr   <= (grant == IDX_W'(N_SRC - 1)) ? '0 : grant + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Directed bench: scheduler plus a behavioural "boab" detector.
module tb_pattern_scan_sched;
  import pattern_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_sync;
  logic [N-1:0]   src_valid, src_last, src_ready;
  logic [N*8-1:0] src_data;
  logic [7:0]     det_data;
  logic           det_ack, det_reset, det_found;
  logic           match_pulse, frame_done, err_gap, busy;
  logic [1:0]     match_src, frame_src;
  logic [7:0]     frame_matches;

  always #5 clk = ~clk;

  pattern_scan_sched #(.N_SRC(N), .CNT_W(8), .DRAIN_CYC(2), .ACK_CYC(2)) dut (
    .clk           (clk),
    .reset_sync    (reset_sync),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_last      (src_last),
    .src_ready     (src_ready),
    .det_data      (det_data),
    .det_ack       (det_ack),
    .det_reset     (det_reset),
    .det_found     (det_found),
    .match_pulse   (match_pulse),
    .match_src     (match_src),
    .frame_done    (frame_done),
    .frame_src     (frame_src),
    .frame_matches (frame_matches),
    .err_gap       (err_gap),
    .busy          (busy)
  );

  // behavioural PatternDetector: found latches on "boab" until acked
  logic [1:0] pd_st;
  always @(posedge clk) begin
    if (det_reset) begin
      pd_st     <= 2'd0;
      det_found <= 1'b0;
    end else if (det_ack) begin
      det_found <= 1'b0;
    end else begin
      case (pd_st)
        2'd0: pd_st <= (det_data == CH_B) ? 2'd1 : 2'd0;
        2'd1: pd_st <= (det_data == CH_O) ? 2'd2 : (det_data == CH_B) ? 2'd1 : 2'd0;
        2'd2: pd_st <= (det_data == CH_A) ? 2'd3 : (det_data == CH_B) ? 2'd1 : 2'd0;
        default: begin
          if (det_data == CH_B) begin
            det_found <= 1'b1;
            pd_st     <= 2'd1;
          end else begin
            pd_st <= 2'd0;
          end
        end
      endcase
    end
  end

  int           n_chk = 0, n_bad = 0;
  int           n_match = 0, n_gap = 0, n_dreset = 0, nbytes = 0;
  int           ack_run = 0, last_ack_run = 0, ack_bad = 0, ready_bad = 0, fr_n = 0;
  logic [1:0]   last_msrc = '0;
  logic [N-1:0] mvalid_at = '0;
  logic [127:0] seen = '0;
  logic [1:0]   fr_src [16];
  logic [7:0]   fr_cnt [16];

  // observe outputs away from the active edge
  always @(negedge clk) begin
    if (match_pulse) begin
      n_match++;
      last_msrc = match_src;
      mvalid_at = src_valid;
    end
    if (frame_done && fr_n < 16) begin
      fr_src[fr_n] = frame_src;
      fr_cnt[fr_n] = frame_matches;
      fr_n++;
    end
    if (err_gap) n_gap++;
    if (det_reset && !reset_sync) n_dreset++;
    if (det_ack) ack_run++;
    else begin
      if (ack_run != 0) begin
        last_ack_run = ack_run;
        if (ack_run != 2) ack_bad++;
      end
      ack_run = 0;
    end
    if (det_ack && src_ready != '0) ready_bad++;
    if ((src_ready & ~src_valid) != '0 || $countones(src_ready) > 1) ready_bad++;
    if (!det_ack && det_data != 8'h00) begin
      seen = {seen[119:0], det_data};
      nbytes++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input string s);
    logic [127:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[119:0], s[i]};
    return v;
  endfunction

  task automatic chk_bytes(input string tag, input string s, input int b0);
    logic [127:0] mask;
    mask = (128'd1 << (8 * s.len())) - 128'd1;
    chk({tag, "_nbytes"}, 128'(nbytes - b0), 128'(s.len()));
    chk({tag, "_bytes"}, seen & mask, pack(s));
  endtask

  task automatic push_byte(input int s, input logic [7:0] b, input logic last);
    int t = 0;
    bit ok = 1'b0;
    src_valid[s] = 1'b1;
    src_data[s*8 +: 8] = b;
    src_last[s] = last;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (src_ready[s]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
      t++;
    end
    chk("accept", 128'(ok), 128'(1));
  endtask

  task automatic send_frame(input int s, input string str);
    for (int i = 0; i < str.len(); i++) push_byte(s, str[i], (i == str.len() - 1));
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int t = 0;
    while (fr_n < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_frames"}, 128'(fr_n), 128'(n));
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  int f, m0, b0, d0, g0;

  initial begin
    reset_sync = 1'b1;
    src_valid  = '0;
    src_last   = '0;
    src_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(src_ready), 128'(0));
    chk("rst_det_reset", 128'(det_reset), 128'(1));
    chk("rst_det_data", 128'(det_data), 128'(0));
    chk("rst_ack", 128'(det_ack), 128'(0));
    chk("rst_outs", 128'({match_pulse, frame_done, err_gap}), 128'(0));
    @(posedge clk);
    #1 reset_sync = 1'b0;

    // 1: src0 "xboabz"
    f = fr_n; m0 = n_match; b0 = nbytes;
    send_frame(0, "xboabz");
    wait_frames(f + 1, "t1");
    chk("t1_matches", 128'(n_match - m0), 128'(1));
    chk("t1_msrc", 128'(last_msrc), 128'(0));
    chk("t1_ack_len", 128'(last_ack_run), 128'(2));
    chk("t1_fsrc", 128'(fr_src[f]), 128'(0));
    chk("t1_fcnt", 128'(fr_cnt[f]), 128'(1));
    chk_bytes("t1", "xboabz", b0);

    // 2: src1 "boab", match resolves in drain
    f = fr_n; m0 = n_match;
    send_frame(1, "boab");
    wait_frames(f + 1, "t2");
    chk("t2_matches", 128'(n_match - m0), 128'(1));
    chk("t2_msrc", 128'(last_msrc), 128'(1));
    chk("t2_after_last", 128'(mvalid_at[1]), 128'(0));
    chk("t2_fsrc", 128'(fr_src[f]), 128'(1));
    chk("t2_fcnt", 128'(fr_cnt[f]), 128'(1));

    // move pointer to 0 with a src3 frame
    f = fr_n;
    send_frame(3, "w");
    wait_frames(f + 1, "t3pre");
    chk("t3pre_fsrc", 128'(fr_src[f]), 128'(3));

    // 3: src0 and src2 together, ptr=0
    f = fr_n; b0 = nbytes;
    src_valid[2] = 1'b1;
    src_data[2*8 +: 8] = "p";
    send_frame(0, "cd");
    send_frame(2, "pq");
    wait_frames(f + 2, "t3");
    chk("t3_first", 128'(fr_src[f]), 128'(0));
    chk("t3_second", 128'(fr_src[f+1]), 128'(2));
    chk_bytes("t3", "cdpq", b0);

    // 4: src3 "boabxboabx"; src1 waiting proves ptr=3
    f = fr_n; m0 = n_match; b0 = nbytes;
    src_valid[1] = 1'b1;
    src_data[1*8 +: 8] = "q";
    send_frame(3, "boabxboabx");
    send_frame(1, "q");
    wait_frames(f + 2, "t4");
    chk("t4_first", 128'(fr_src[f]), 128'(3));
    chk("t4_second", 128'(fr_src[f+1]), 128'(1));
    chk("t4_matches", 128'(n_match - m0), 128'(2));
    chk("t4_msrc", 128'(last_msrc), 128'(3));
    chk("t4_fcnt", 128'(fr_cnt[f]), 128'(2));
    chk("t4_fcnt_q", 128'(fr_cnt[f+1]), 128'(0));
    chk_bytes("t4", "boabxboabxq", b0);

    // 5: src0 "bo" then "abx", no cross-frame match
    f = fr_n; m0 = n_match; d0 = n_dreset;
    send_frame(0, "bo");
    send_frame(0, "abx");
    wait_frames(f + 2, "t5");
    chk("t5_matches", 128'(n_match - m0), 128'(0));
    chk("t5_flushes", 128'(n_dreset - d0), 128'(2));
    chk("t5_fcnt0", 128'(fr_cnt[f]), 128'(0));
    chk("t5_fcnt1", 128'(fr_cnt[f+1]), 128'(0));
    chk("t5_fsrc1", 128'(fr_src[f+1]), 128'(0));

    // 6: src2 drops valid after "bo"
    f = fr_n; g0 = n_gap;
    push_byte(2, CH_B, 1'b0);
    push_byte(2, CH_O, 1'b0);
    src_valid[2] = 1'b0;
    wait_frames(f + 1, "t6");
    chk("t6_gap", 128'(n_gap - g0), 128'(1));
    chk("t6_fsrc", 128'(fr_src[f]), 128'(2));
    chk("t6_fcnt", 128'(fr_cnt[f]), 128'(0));

    // 6b: reset in the middle of a frame
    push_byte(2, CH_B, 1'b0);
    chk("t6r_busy_pre", 128'(busy), 128'(1));
    reset_sync   = 1'b1;
    src_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6r_busy", 128'(busy), 128'(0));
    chk("t6r_ready", 128'(src_ready), 128'(0));
    chk("t6r_det_data", 128'(det_data), 128'(0));
    chk("t6r_det_reset", 128'(det_reset), 128'(1));
    chk("t6r_pulses", 128'({det_ack, match_pulse, frame_done, err_gap}), 128'(0));
    chk("t6r_fields", 128'({match_src, frame_src, frame_matches}), 128'(0));
    f = fr_n;
    @(posedge clk);
    #1 reset_sync = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6r_no_frame", 128'(fr_n), 128'(f));
    chk("t6r_idle", 128'(busy), 128'(0));

    chk("ack_len_all", 128'(ack_bad), 128'(0));
    chk("ready_rules", 128'(ready_bad), 128'(0));
    chk("gap_total", 128'(n_gap), 128'(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
